// File: rtl/mul_operand_sequencer.sv
// Feeds one signed operand pair at a time into a serial-load multiplier (start, A, B),
// captures the product on a done rising edge. Optional watchdog: define MUL_WATCHDOG_EN.
module mul_operand_sequencer #(
    parameter int SIZE    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   in_a,
    input  logic [SIZE-1:0]   in_b,
    output logic              mul_reset,
    output logic              mul_start,
    output logic [SIZE-1:0]   mul_data_in,
    input  logic [2*SIZE-1:0] mul_data_out,
    input  logic              mul_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] out_product,
    output logic              err_timeout,
    output logic [2:0]        dbg_state_o
);

    // Both interfaces are valid/ready: a transfer happens on a rising clk edge where
    // valid and ready are both high; the sender holds valid and payload until then.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        LOAD_A = 3'd2,
        LOAD_B = 3'd3,
        WAIT   = 3'd4,
        HOLD   = 3'd5
    } state_t;

    state_t              state_q;
    logic [SIZE-1:0]     a_q;
    logic [SIZE-1:0]     b_q;
    logic                mul_reset_q;
    logic                mul_start_q;
    logic [SIZE-1:0]     data_q;
    logic                done_d_q;
    logic                out_valid_q;
    logic [2*SIZE-1:0]   product_q;

`ifdef MUL_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    wd_cnt_q;
    logic                err_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mul_reset_q <= 1'b1;
            mul_start_q <= 1'b0;
            data_q      <= '0;
            done_d_q    <= 1'b0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
`ifdef MUL_WATCHDOG_EN
            wd_cnt_q    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            done_d_q    <= mul_done;
            mul_reset_q <= 1'b0;
            mul_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q         <= in_a;
                        b_q         <= in_b;
                        mul_start_q <= 1'b1;
                        data_q      <= '0;
                        state_q     <= START;
                    end
                end
                START: begin
                    data_q  <= a_q;
                    state_q <= LOAD_A;
                end
                LOAD_A: begin
                    data_q  <= b_q;
                    state_q <= LOAD_B;
                end
                LOAD_B: begin
`ifdef MUL_WATCHDOG_EN
                    wd_cnt_q <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Only a fresh rising edge counts; a done left high from earlier is ignored.
                    if (mul_done && !done_d_q) begin
                        product_q   <= mul_data_out;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
`ifdef MUL_WATCHDOG_EN
                    else if (wd_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        mul_reset_q <= 1'b1;
                        err_q       <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + CNT_W'(1);
                    end
`endif
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE) && !reset;
    assign mul_reset   = mul_reset_q;
    assign mul_start   = mul_start_q;
    assign mul_data_in = data_q;
    assign out_valid   = out_valid_q;
    assign out_product = product_q;
    assign dbg_state_o = state_q;

`ifdef MUL_WATCHDOG_EN
    assign err_timeout = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign err_timeout    = 1'b0;
`endif

endmodule

// File: doc/mul_operand_sequencer.md
Name: mul_operand_sequencer

Overview:
- Upstream feeder for the serial-load signed multiplier (ports start/reset/clk/data_in/data_out/done).
- Accepts one operand pair (A, B) on a valid/ready interface and drives the multiplier's load protocol: start pulse, then A, then B, on consecutive cycles.
- Waits for the multiplier's done, captures the 2*SIZE product and presents it on a valid/ready result interface.
- Sits between the operand source (FIFO/testbench) and the multiplier; exactly one operation is in flight at a time.

Parameters:
- SIZE, 8, operand width; product width is 2*SIZE.
- TIMEOUT, 64, max WAIT cycles before abort; used only with MUL_WATCHDOG_EN.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept a pair.
- in_a  input  SIZE  multiplicand A, two's complement.
- in_b  input  SIZE  multiplier B, two's complement.
- mul_reset  output  1  reset to the multiplier.
- mul_start  output  1  start pulse to the multiplier.
- mul_data_in  output  SIZE  serial operand bus to the multiplier.
- mul_data_out  input  2*SIZE  product from the multiplier.
- mul_done  input  1  multiplier completion.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts the product.
- out_product  output  2*SIZE  captured signed product.
- err_timeout  output  1  sticky abort flag; constant 0 without MUL_WATCHDOG_EN.

Behaviour:
- Reset values, while reset=1 and in the following cycle: state IDLE; in_ready=0 while reset=1; mul_reset=1; mul_start=0; mul_data_in=0; out_valid=0; out_product=0; err_timeout=0; done_d=0.
- Reset is sampled on clk only. Asserting it mid-operation aborts the operation at the next edge, discards any held product, and returns to IDLE.
- mul_reset is registered: 1 during reset or an abort, otherwise 0.
- States: IDLE, START, LOAD_A, LOAD_B, WAIT, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register in_a and in_b, then go to START.
- START: mul_start=1 for exactly one cycle; mul_data_in=0; go to LOAD_A.
- LOAD_A: mul_start=0; mul_data_in=A for one cycle; go to LOAD_B.
- LOAD_B: mul_data_in=B for one cycle; go to WAIT.
- WAIT:
  - mul_data_in holds B.
  - done_d registers mul_done each cycle.
  - On a rising edge (mul_done & ~done_d), capture mul_data_out into out_product and go to HOLD.
  - A level-high done without a rising edge is ignored.
- HOLD:
  - out_valid=1; out_product stable.
  - When out_valid&out_ready, go to IDLE with out_valid=0 the next cycle.
  - in_ready=0 throughout HOLD; no overlap of operations.
- in_ready=0 in every state except IDLE.
- Latency: accept at edge t; mul_start high in cycle t+1, A in t+2, B in t+3. out_valid rises one cycle after the done rising edge is sampled.
- mul_done rising in START, LOAD_A or LOAD_B is ignored (done_d is still updated).
- Product is passed through bit-exact; no sign extension or truncation.

Optional Feature:
- Macro: MUL_WATCHDOG_EN.
- When defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with no done edge, the block pulses mul_reset for 1 cycle, sets err_timeout, and returns to IDLE. No out_valid is produced for that operation.
  - err_timeout stays set until reset.
- When undefined: no counter; WAIT is unbounded; err_timeout tied to 0.

Test Plan:
- Reset then A=14, B=5 -> mul_start high exactly 1 cycle; mul_data_in 14 then 5 on the next 2 cycles; out_product=16'h0046 with out_valid held.
- A=51, B=-3 (8'hFD), out_ready held low 20 cycles -> out_valid and out_product=16'hFF67 stable; in_ready=0 throughout; accepted when out_ready=1.
- Back-to-back pairs (4,10), (11,-6), (7,-19) with in_valid always high -> products 16'h0028, 16'hFFBE, 16'hFF7B in order; each start pulse follows an IDLE cycle.
- Reset asserted in WAIT of A=7, B=-19 -> next cycle state IDLE, mul_reset=1, out_valid never asserts; the next pair completes normally.
- mul_done forced high before WAIT and held -> no capture until a fresh rising edge in WAIT.
- With MUL_WATCHDOG_EN and TIMEOUT=16, mul_done stuck low -> mul_reset pulse and err_timeout=1 after 16 WAIT cycles; in_ready=1 next cycle.
